sram_2048x32_req_ctrl: RTL and testbench

Initiator-side controller for the 2048x32 single-port SRAM macro used by the accumulator buffers of the MAC engine. Accepts independent write and read request streams over valid/ready handshakes and arbitrates them onto the single SRAM port. Drives active-low CEB/WEB with registered address and data, and returns read data through a credit-protected response FIFO. It is the only agent that drives the macro pins.

---
 rtl/sram_2048x32_req_ctrl_pkg.sv | 22 ++
 rtl/sram_2048x32_req_ctrl_if.sv | 34 +++
 rtl/sram_2048x32_req_ctrl_rsp_fifo.sv | 65 ++++++
 rtl/sram_2048x32_req_ctrl.sv | 138 +++++++++++++
 tb/tb_sram_2048x32_req_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_2048x32_req_ctrl_pkg.sv
// Shared definitions for the 2048x32 SRAM request controller.
//   SRAM_ADDR_W / SRAM_DATA_W : macro geometry
//   sram_grant_e              : which request stream owned the port last
//   sram_req_t                : one registered access on the macro pins
package sram_2048x32_req_ctrl_pkg;

    localparam int unsigned SRAM_ADDR_W = 11;
    localparam int unsigned SRAM_DATA_W = 32;

    typedef enum logic {
        GRANT_WRITE = 1'b0,
        GRANT_READ  = 1'b1
    } sram_grant_e;

    typedef struct packed {
        logic                   ceb;
        logic                   web;
        logic [SRAM_ADDR_W-1:0] a;
        logic [SRAM_DATA_W-1:0] d;
    } sram_req_t;

endpackage

// File: rtl/sram_2048x32_req_ctrl_if.sv
// Request/response streams of the SRAM controller.
//   wr_*  : write request (valid/ready, addr, data)
//   rd_*  : read request (valid/ready, addr)
//   rsp_* : read response (valid/ready, data)
// slave is the controller side, master is the requester side.
interface sram_2048x32_req_ctrl_if
    import sram_2048x32_req_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = SRAM_ADDR_W,
    parameter int unsigned DATA_W = SRAM_DATA_W
) ();

    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_valid;
    logic              rd_ready;
    logic [ADDR_W-1:0] rd_addr;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;

    modport slave (
        input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr, rsp_ready,
        output wr_ready, rd_ready, rsp_valid, rsp_data
    );

    modport master (
        output wr_valid, wr_addr, wr_data, rd_valid, rd_addr, rsp_ready,
        input  wr_ready, rd_ready, rsp_valid, rsp_data
    );

endinterface

// File: rtl/sram_2048x32_req_ctrl_rsp_fifo.sv
// Read response FIFO, DEPTH x DATA_W, power-of-two depth with wrapping pointers.
//   push_i/push_data_i : write one entry (caller guarantees no overflow)
//   pop_i              : consume head when valid_o
//   valid_o/data_o     : head entry; data_o reads 0 while empty
//   count_o            : current occupancy
// A push into a full FIFO is legal when the head is popped in the same cycle.
module sram_2048x32_req_ctrl_rsp_fifo
    import sram_2048x32_req_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = SRAM_DATA_W,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [CNT_W-1:0]  count_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              pop_ok;

    assign pop_ok  = pop_i && (count_q != '0);
    assign valid_o = (count_q != '0);
    assign data_o  = valid_o ? mem_q[rptr_q] : '0;
    assign count_o = count_q;

    always_comb begin
        wptr_d  = push_i ? wptr_q + PTR_W'(1) : wptr_q;
        rptr_d  = pop_ok ? rptr_q + PTR_W'(1) : rptr_q;
        count_d = count_q;
        unique case ({push_i, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/sram_2048x32_req_ctrl.sv
// Initiator-side controller for the 2048x32 single-port SRAM macro.
//   clk_i, rst_ni          : clock (shared with macro CLK), async active-low reset
//   bus_if                 : write/read request and read response streams
//   sram_ceb_o/web_o/a_o/d_o : registered macro pins (CEB, WEB active-low)
//   sram_q_i               : macro read data, valid the cycle after a read issue
//   idle_o                 : no access on the pins, no read in flight, FIFO empty
// Write and read streams are round-robin arbitrated onto the single port; reads
// need a credit so that every issued read has a guaranteed FIFO slot.
module sram_2048x32_req_ctrl
    import sram_2048x32_req_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W    = SRAM_ADDR_W,
    parameter int unsigned DATA_W    = SRAM_DATA_W,
    parameter int unsigned RSP_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    sram_2048x32_req_ctrl_if.slave bus_if,
    output logic                  sram_ceb_o,
    output logic                  sram_web_o,
    output logic [ADDR_W-1:0]     sram_a_o,
    output logic [DATA_W-1:0]     sram_d_o,
    input  logic [DATA_W-1:0]     sram_q_i,
    output logic                  idle_o
);

    localparam int unsigned CNT_W = $clog2(RSP_DEPTH) + 1;
    localparam int unsigned USE_W = CNT_W + 1;

    sram_grant_e      last_grant_q, last_grant_d;
    sram_req_t        req_q, req_d;
    logic             issue_rd_q;
    logic             cap_vld_q;
    logic [1:0]       inflight_q, inflight_d;
    logic [CNT_W-1:0] fifo_count;
    logic [USE_W-1:0] slots_used;
    logic             credit;
    logic             rd_req;
    logic             grant_wr, grant_rd;

    // Every read from accept until FIFO push holds a slot, so the FIFO cannot overflow.
    assign slots_used = USE_W'(fifo_count) + USE_W'(inflight_q);
    assign credit     = slots_used < USE_W'(RSP_DEPTH);
    assign rd_req     = bus_if.rd_valid && credit;

    // A read without credit is invisible to the arbiter, so it never stalls a write.
    always_comb begin
        grant_wr = 1'b0;
        grant_rd = 1'b0;
        if (bus_if.wr_valid && rd_req) begin
            if (last_grant_q == GRANT_READ) begin
                grant_wr = 1'b1;
            end else begin
                grant_rd = 1'b1;
            end
        end else if (bus_if.wr_valid) begin
            grant_wr = 1'b1;
        end else if (rd_req) begin
            grant_rd = 1'b1;
        end
    end

    assign bus_if.wr_ready = grant_wr;
    assign bus_if.rd_ready = grant_rd && credit;

    always_comb begin
        last_grant_d = last_grant_q;
        if (grant_wr) begin
            last_grant_d = GRANT_WRITE;
        end else if (grant_rd) begin
            last_grant_d = GRANT_READ;
        end
    end

    // Address/data hold their last value between accesses to avoid pin toggling.
    always_comb begin
        req_d     = req_q;
        req_d.ceb = 1'b1;
        req_d.web = 1'b1;
        if (grant_wr) begin
            req_d.ceb = 1'b0;
            req_d.web = 1'b0;
            req_d.a   = bus_if.wr_addr;
            req_d.d   = bus_if.wr_data;
        end else if (grant_rd) begin
            req_d.ceb = 1'b0;
            req_d.a   = bus_if.rd_addr;
        end
    end

    always_comb begin
        inflight_d = inflight_q;
        unique case ({grant_rd, cap_vld_q})
            2'b10:   inflight_d = inflight_q + 2'd1;
            2'b01:   inflight_d = inflight_q - 2'd1;
            default: inflight_d = inflight_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_grant_q <= GRANT_READ;
            req_q        <= '{ceb: 1'b1, web: 1'b1, a: '0, d: '0};
            issue_rd_q   <= 1'b0;
            cap_vld_q    <= 1'b0;
            inflight_q   <= 2'd0;
        end else begin
            last_grant_q <= last_grant_d;
            req_q        <= req_d;
            issue_rd_q   <= grant_rd;
            cap_vld_q    <= issue_rd_q;
            inflight_q   <= inflight_d;
        end
    end

    assign sram_ceb_o = req_q.ceb;
    assign sram_web_o = req_q.web;
    assign sram_a_o   = req_q.a;
    assign sram_d_o   = req_q.d;

    // cap_vld_q marks the cycle in which sram_q_i carries the issued read's data.
    sram_2048x32_req_ctrl_rsp_fifo #(
        .DEPTH  (RSP_DEPTH),
        .DATA_W (DATA_W)
    ) u_rsp_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (cap_vld_q),
        .push_data_i (sram_q_i),
        .pop_i       (bus_if.rsp_ready),
        .valid_o     (bus_if.rsp_valid),
        .data_o      (bus_if.rsp_data),
        .count_o     (fifo_count)
    );

    assign idle_o = req_q.ceb && (inflight_q == 2'd0) && (fifo_count == '0);

endmodule

// File: tb/tb_sram_2048x32_req_ctrl.sv
// Bench for sram_2048x32_req_ctrl: directed scenarios plus a random phase, all
// checked every cycle against a transaction-level model (golden memory updated in
// acceptance order, queue of outstanding read responses with accept time).
module tb_sram_2048x32_req_ctrl;

    localparam int RSP_DEPTH = 4;

    typedef struct {
        logic [31:0] data;
        int          edge_n;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sram_ceb, sram_web, idle;
    logic [10:0] sram_a;
    logic [31:0] sram_d;
    logic [31:0] sram_q;
    logic [31:0] macro_mem [2048];

    sram_2048x32_req_ctrl_if bus_if ();

    sram_2048x32_req_ctrl #(
        .RSP_DEPTH (RSP_DEPTH)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .bus_if     (bus_if),
        .sram_ceb_o (sram_ceb),
        .sram_web_o (sram_web),
        .sram_a_o   (sram_a),
        .sram_d_o   (sram_d),
        .sram_q_i   (sram_q),
        .idle_o     (idle)
    );

    always #5 clk = ~clk;

    // Behavioural single-port macro: samples pins on the rising edge.
    always @(posedge clk) begin
        if (!sram_ceb) begin
            if (!sram_web) macro_mem[sram_a] <= sram_d;
            else           sram_q <= macro_mem[sram_a];
        end
    end

    int          n_tests = 0;
    int          n_fail  = 0;
    int          edge_n  = 0;
    int          n_rd_acc;
    logic [31:0] ref_mem [2048];
    rsp_t        exp_q [$];
    logic [31:0] popped [$];
    logic        exp_last_rd;
    logic        exp_ceb, exp_web;
    logic [10:0] exp_a;
    logic [31:0] exp_d;
    logic        last_wr_acc, last_rd_acc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check outputs against the model, then advance both.
    task automatic cycle();
        logic credit, rd_can, ew, er, vis, pop;
        #2;
        credit = exp_q.size() < RSP_DEPTH;
        rd_can = bus_if.rd_valid && credit;
        ew = 1'b0;
        er = 1'b0;
        if (bus_if.wr_valid && rd_can) begin
            if (exp_last_rd) ew = 1'b1; else er = 1'b1;
        end else if (bus_if.wr_valid) ew = 1'b1;
        else if (rd_can) er = 1'b1;
        check("wr_ready", bus_if.wr_ready, ew);
        check("rd_ready", bus_if.rd_ready, er);
        check("sram_ceb", sram_ceb, exp_ceb);
        check("sram_web", sram_web, exp_web);
        if (!exp_ceb) check("sram_a", sram_a, exp_a);
        if (!exp_ceb && !exp_web) check("sram_d", sram_d, exp_d);
        check("idle", idle, exp_q.size() == 0 && exp_ceb);
        vis = exp_q.size() != 0 && (exp_q[0].edge_n + 2 <= edge_n);
        check("rsp_valid", bus_if.rsp_valid, vis);
        if (vis) check("rsp_data", bus_if.rsp_data, exp_q[0].data);
        pop = vis && bus_if.rsp_ready;
        @(posedge clk);
        edge_n++;
        if (pop) popped.push_back(exp_q.pop_front().data);
        last_wr_acc = ew;
        last_rd_acc = er;
        exp_ceb = 1'b1;
        exp_web = 1'b1;
        if (ew) begin
            ref_mem[bus_if.wr_addr] = bus_if.wr_data;
            exp_ceb = 1'b0;
            exp_web = 1'b0;
            exp_a = bus_if.wr_addr;
            exp_d = bus_if.wr_data;
            exp_last_rd = 1'b0;
        end else if (er) begin
            exp_q.push_back('{ref_mem[bus_if.rd_addr], edge_n});
            exp_ceb = 1'b0;
            exp_a = bus_if.rd_addr;
            exp_last_rd = 1'b1;
            n_rd_acc++;
        end
        #1;
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_ceb = 1'b1;
        exp_web = 1'b1;
        exp_a = '0;
        exp_d = '0;
        exp_last_rd = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus_if.wr_valid = 1'b0;
        bus_if.rd_valid = 1'b0;
        @(posedge clk);
        #1;
        check("rst_ceb", sram_ceb, 1'b1);
        check("rst_web", sram_web, 1'b1);
        check("rst_a", sram_a, 11'h0);
        check("rst_d", sram_d, 32'h0);
        check("rst_rsp_valid", bus_if.rsp_valid, 1'b0);
        check("rst_rsp_data", bus_if.rsp_data, 32'h0);
        check("rst_idle", idle, 1'b1);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic drain();
        bus_if.wr_valid = 1'b0;
        bus_if.rd_valid = 1'b0;
        bus_if.rsp_ready = 1'b1;
        for (int i = 0; i < 40 && (exp_q.size() != 0 || !exp_ceb); i++) cycle();
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        bus_if.wr_valid = 1'b0;
        bus_if.rd_valid = 1'b0;
        bus_if.wr_addr = '0;
        bus_if.wr_data = '0;
        bus_if.rd_addr = '0;
        bus_if.rsp_ready = 1'b1;
        n_rd_acc = 0;
        model_reset();
        do_reset();

        // 1: write then read 0x7FF, latency check
        bus_if.wr_valid = 1'b1;
        bus_if.wr_addr = 11'h7FF;
        bus_if.wr_data = 32'hDEADBEEF;
        cycle();
        check("t1_wr_pins", {sram_ceb, sram_web}, 2'b00);
        bus_if.wr_valid = 1'b0;
        bus_if.rd_valid = 1'b1;
        bus_if.rd_addr = 11'h7FF;
        cycle();
        check("t1_rd_pins", {sram_ceb, sram_web}, 2'b01);
        bus_if.rd_valid = 1'b0;
        cycle();
        check("t1_rsp_not_yet", bus_if.rsp_valid, 1'b0);
        cycle();
        check("t1_rsp_valid", bus_if.rsp_valid, 1'b1);
        check("t1_rsp_data", bus_if.rsp_data, 32'hDEADBEEF);
        drain();

        // Preload addresses 0..31 through the controller
        bus_if.wr_valid = 1'b1;
        for (int a = 0; a < 32; a++) begin
            bus_if.wr_addr = 11'(a);
            bus_if.wr_data = $urandom;
            cycle();
        end
        bus_if.wr_valid = 1'b0;

        // 2: both ports valid for 8 cycles after reset
        do_reset();
        bus_if.wr_valid = 1'b1;
        bus_if.rd_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus_if.wr_addr = 11'($urandom_range(0, 31));
            bus_if.wr_data = $urandom;
            bus_if.rd_addr = 11'($urandom_range(0, 31));
            cycle();
            check("t2_grant_wr", last_wr_acc, (i % 2) == 0);
            check("t2_one_access", sram_ceb, 1'b0);
        end
        drain();

        // 3: six reads with the response side stalled
        popped.delete();
        bus_if.rsp_ready = 1'b0;
        bus_if.rd_valid = 1'b1;
        k = 0;
        bus_if.rd_addr = 11'(k);
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (last_rd_acc) begin
                k++;
                bus_if.rd_addr = 11'(k);
            end
        end
        #1;
        check("t3_accepted", k, 4);
        check("t3_rd_ready_low", bus_if.rd_ready, 1'b0);
        check("t3_rsp_held", bus_if.rsp_valid, 1'b1);
        bus_if.rsp_ready = 1'b1;
        for (int i = 0; i < 40 && (k < 6 || exp_q.size() != 0); i++) begin
            cycle();
            if (last_rd_acc) begin
                k++;
                bus_if.rd_addr = 11'(k);
                if (k == 6) bus_if.rd_valid = 1'b0;
            end
        end
        check("t3_total", k, 6);
        check("t3_pop_count", popped.size(), 6);
        for (int i = 0; i < 6 && i < popped.size(); i++) check("t3_order", popped[i], ref_mem[i]);
        drain();

        // 4: write must not be blocked by a read lacking credit
        bus_if.rsp_ready = 1'b0;
        bus_if.rd_valid = 1'b1;
        k = 0;
        for (int i = 0; i < 10 && k < 4; i++) begin
            bus_if.rd_addr = 11'($urandom_range(0, 31));
            cycle();
            if (last_rd_acc) k++;
        end
        check("t4_filled", k, 4);
        bus_if.rd_valid = 1'b0;
        bus_if.wr_valid = 1'b1;
        bus_if.wr_addr = 11'h005;
        bus_if.wr_data = 32'h0000_5555;
        cycle();
        bus_if.rd_valid = 1'b1;
        bus_if.wr_addr = 11'h006;
        bus_if.wr_data = 32'h0000_6666;
        #1;
        check("t4_wr_ready", bus_if.wr_ready, 1'b1);
        check("t4_rd_ready", bus_if.rd_ready, 1'b0);
        cycle();
        check("t4_wr_accepted", last_wr_acc, 1'b1);
        drain();

        // 5: read-after-write and write-after-read ordering
        popped.delete();
        bus_if.wr_valid = 1'b1;
        bus_if.wr_addr = 11'h010;
        bus_if.wr_data = 32'd1;
        cycle();
        bus_if.wr_valid = 1'b0;
        bus_if.rd_valid = 1'b1;
        bus_if.rd_addr = 11'h010;
        cycle();
        bus_if.rd_valid = 1'b0;
        bus_if.wr_valid = 1'b1;
        bus_if.wr_addr = 11'h020;
        bus_if.wr_data = 32'd9;
        cycle();
        bus_if.wr_valid = 1'b0;
        bus_if.rd_valid = 1'b1;
        bus_if.rd_addr = 11'h020;
        cycle();
        bus_if.rd_valid = 1'b0;
        bus_if.wr_valid = 1'b1;
        bus_if.wr_data = 32'd5;
        cycle();
        drain();
        check("t5_raw", popped.size() > 0 ? popped[0] : 32'hX, 32'd1);
        check("t5_war", popped.size() > 1 ? popped[1] : 32'hX, 32'd9);

        // 6: reset one cycle after a read accept
        bus_if.rd_valid = 1'b1;
        bus_if.rd_addr = 11'h003;
        cycle();
        bus_if.rd_valid = 1'b0;
        check("t6_issued", sram_ceb, 1'b0);
        rst_n = 1'b0;
        #1;
        check("t6_ceb", sram_ceb, 1'b1);
        check("t6_rsp_valid", bus_if.rsp_valid, 1'b0);
        check("t6_idle", idle, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 5; i++) cycle();

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            bus_if.wr_valid = 1'($urandom_range(0, 1));
            bus_if.rd_valid = 1'($urandom_range(0, 1));
            bus_if.wr_addr = 11'($urandom_range(0, 31));
            bus_if.wr_data = $urandom;
            bus_if.rd_addr = 11'($urandom_range(0, 31));
            bus_if.rsp_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
